// File: rtl/mem_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
//   owner_e        : who owns the read data returning next cycle
//   MEM_AW_DEFAULT : default memory word-address width
//   WORD_BYTES     : bytes per memory word
package mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int MEM_AW_DEFAULT = 10;
  localparam int WORD_BYTES     = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-winner pointer.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_req[1:0] : requests, bit 0 = fetch, bit 1 = data
//   o_gnt[1:0] : one-hot (or zero) grant, combinational from i_req/pointer/reset
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // 1 = data won the most recent granted cycle, 0 = fetch did.
  logic r_last_d;

  // Grant selection: a lone request wins; on conflict the previous loser wins.
  always_comb begin
    o_gnt = 2'b00;
    if (reset) begin
      o_gnt = 2'b00;
    end else if (i_req == 2'b11) begin
      o_gnt = r_last_d ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
  end

  // Pointer moves only on cycles that actually grant something.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (|o_gnt) begin
      r_last_d <= o_gnt[1];
    end else begin
      r_last_d <= r_last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous-read memory between the fetch port (i_*)
// and the load/store port (d_*). One access per cycle, round-robin on conflict,
// read data routed back to its owner one cycle after the grant.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata : fetch requester
//   d_req/d_we/d_be/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata : data requester
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata, mem_rdata : memory side
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = MEM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_d_write;
  owner_e     r_owner;

  // Byte-offset bits and bits above the memory range carry no meaning here.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                                d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

  assign w_req = {d_req, i_req};

  rr_arbiter2 u_rr_arbiter2 (
    .clk   (clk),
    .reset (reset),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  // Grants and memory drive; every memory output is held at 0 when idle.
  always_comb begin
    i_gnt     = w_gnt[0];
    d_gnt     = w_gnt[1];
    w_d_write = w_gnt[1] & d_we;
    mem_en    = |w_gnt;
    mem_we    = w_d_write;
    mem_be    = 4'b0000;
    mem_addr  = {MEM_AW{1'b0}};
    mem_wdata = 32'h0000_0000;
    if (mem_en) begin
      mem_be    = w_d_write ? d_be : 4'b1111;
      mem_addr  = w_gnt[1] ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
      mem_wdata = d_wdata;
    end else begin
      mem_be    = 4'b0000;
      mem_addr  = {MEM_AW{1'b0}};
      mem_wdata = 32'h0000_0000;
    end
  end

  // Remember which port's read is in flight; writes produce no response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_NONE;
    end else if (w_gnt[0]) begin
      r_owner <= OWN_I;
    end else if (w_gnt[1] && !d_we) begin
      r_owner <= OWN_D;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  // Response routing; reset masks a read granted just before it was asserted.
  always_comb begin
    i_rvalid = (r_owner == OWN_I) && !reset;
    d_rvalid = (r_owner == OWN_D) && !reset;
    i_rdata  = i_rvalid ? mem_rdata : 32'h0000_0000;
    d_rdata  = d_rvalid ? mem_rdata : 32'h0000_0000;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(.ADDR_W(32), .MEM_AW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory attached to the DUT (synchronous read, byte-write).
  logic [31:0] phys_mem [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) phys_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= phys_mem[mem_addr];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [1024];
  bit          m_d_won_last;
  bit          pend_i, pend_d;
  logic [31:0] pend_i_data, pend_d_data;

  int total = 0;
  int bad   = 0;

  // Observations from the latest step.
  logic        obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid;
  logic [31:0] obs_i_rdata, obs_d_rdata;
  logic [9:0]  obs_mem_addr;

  function automatic logic [31:0] preload(input int k);
    logic [31:0] kk;
    kk = k;
    if (k == 4) return 32'h1111_1111;
    return 32'h5A5A_0000 ^ (kk * 32'h0001_0307);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check everything against the model, advance model.
  task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic dwe, input logic [3:0] dbe,
                      input logic [31:0] daddr, input logic [31:0] dwdata,
                      output logic gi, output logic gd);
    logic        en;
    logic [9:0]  idx;
    logic        exp_iv, exp_dv;
    @(negedge clk);
    reset = rst; i_req = ireq; i_addr = iaddr;
    d_req = dreq; d_we = dwe; d_be = dbe; d_addr = daddr; d_wdata = dwdata;
    #1;
    if (rst) begin
      gi = 1'b0; gd = 1'b0;
    end else if (ireq && dreq) begin
      gd = !m_d_won_last; gi = m_d_won_last;
    end else begin
      gi = ireq; gd = dreq;
    end
    en  = gi | gd;
    idx = gd ? daddr[11:2] : iaddr[11:2];
    exp_iv = pend_i && !rst;
    exp_dv = pend_d && !rst;

    chk("i_gnt", {31'd0, i_gnt}, {31'd0, gi});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, gd});
    chk("mem_en", {31'd0, mem_en}, {31'd0, en});
    chk("mem_we", {31'd0, mem_we}, {31'd0, gd & dwe});
    chk("mem_be", {28'd0, mem_be}, {28'd0, en ? ((gd && dwe) ? dbe : 4'hF) : 4'h0});
    chk("mem_addr", {22'd0, mem_addr}, {22'd0, en ? idx : 10'd0});
    chk("mem_wdata", mem_wdata, en ? dwdata : 32'h0);
    chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, exp_iv});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_dv});
    chk("i_rdata", i_rdata, exp_iv ? pend_i_data : 32'h0);
    chk("d_rdata", d_rdata, exp_dv ? pend_d_data : 32'h0);

    obs_i_gnt = i_gnt; obs_d_gnt = d_gnt;
    obs_i_rvalid = i_rvalid; obs_d_rvalid = d_rvalid;
    obs_i_rdata = i_rdata; obs_d_rdata = d_rdata; obs_mem_addr = mem_addr;

    if (rst) begin
      m_d_won_last = 1'b0;
      pend_i = 1'b0; pend_d = 1'b0;
    end else begin
      if (en) m_d_won_last = gd;
      pend_i = gi;
      pend_d = gd && !dwe;
      pend_i_data = ref_mem[idx];
      pend_d_data = ref_mem[idx];
      if (gd && dwe)
        for (int b = 0; b < 4; b++)
          if (dbe[b]) ref_mem[idx][8*b +: 8] = dwdata[8*b +: 8];
    end
  endtask

  initial begin
    logic        gi, gd;
    logic        ri, rd, rwe, rs, hi, hd;
    logic [3:0]  rbe;
    logic [31:0] ia, da, dw, first_data;

    for (int k = 0; k < 1024; k++) begin
      phys_mem[k] = preload(k);
      ref_mem[k]  = preload(k);
    end
    mem_rdata = 32'h0;
    reset = 1'b1; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    m_d_won_last = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
    pend_i_data = 32'h0; pend_d_data = 32'h0;

    // Reset held 3 cycles with both requests high.
    for (int n = 0; n < 3; n++)
      step(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, gi, gd);

    // Continuous contention: D, I, D, I, D, I.
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 1'b1, 32'h100 + 32'(n * 4), 1'b1, 1'b0, 4'hF, 32'h200 + 32'(n * 4),
           32'h0, gi, gd);
      chk("contention_d", {31'd0, obs_d_gnt}, (n % 2 == 0) ? 32'd1 : 32'd0);
      chk("contention_i", {31'd0, obs_i_gnt}, (n % 2 == 0) ? 32'd0 : 32'd1);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);

    // Fetch alone at 0x8.
    step(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("fetch_gnt", {31'd0, obs_i_gnt}, 32'd1);
    chk("fetch_addr", {22'd0, obs_mem_addr}, 32'd2);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("fetch_rvalid", {31'd0, obs_i_rvalid}, 32'd1);
    chk("fetch_rdata", obs_i_rdata, preload(2));
    chk("fetch_no_drvalid", {31'd0, obs_d_rvalid}, 32'd0);

    // Byte write then read back.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h10, 32'hAABB_CCDD, gi, gd);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, gi, gd);
    chk("write_no_rvalid", {31'd0, obs_d_rvalid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("byte_merge", obs_d_rdata, 32'h1111_CC11);

    // Reset cancels an in-flight fetch.
    step(1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("reset_cancel_n1", {31'd0, obs_i_rvalid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("reset_cancel_n2", {31'd0, obs_i_rvalid}, 32'd0);

    // Low address bits ignored.
    step(1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("ign_addr3", {22'd0, obs_mem_addr}, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("ign_addr0", {22'd0, obs_mem_addr}, 32'd0);
    first_data = obs_i_rdata;
    chk("ign_data3", first_data, preload(0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    chk("ign_same_data", obs_i_rdata, first_data);

    // Randomized traffic; requesters hold their request until granted.
    hi = 1'b0; hd = 1'b0;
    ri = 1'b0; rd = 1'b0; rwe = 1'b0; rbe = 4'h0; ia = 32'h0; da = 32'h0; dw = 32'h0;
    for (int n = 0; n < 300; n++) begin
      if (!hi) begin
        ri = 1'($urandom_range(0, 1));
        ia = $urandom;
      end
      if (!hd) begin
        rd  = 1'($urandom_range(0, 1));
        rwe = 1'($urandom_range(0, 1));
        rbe = 4'($urandom_range(0, 15));
        da  = $urandom;
        dw  = $urandom;
      end
      rs = ($urandom_range(0, 39) == 0);
      step(rs, ri, ia, rd, rwe, rbe, da, dw, gi, gd);
      hi = ri && !gi;
      hd = rd && !gd;
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
